// File: rtl/output_port_arbiter_if.sv
// Flit request/response bundle between the input datapaths and the output arbiter.
//   fin_req_i   NUM_IN packed flits, input k at [k*FLIT_W +: FLIT_W], bit 0 of each is valid
//   fin_resp_o  per-input ready back to the input datapaths
//   fout_req_o  registered output flit towards the downstream link, bit 0 is valid
//   fout_resp_i ready from the downstream link
// The slave modport is the arbiter side; the master modport drives the inputs and the link ready.
interface output_port_arbiter_if #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned FLIT_W = 37
);
    logic [NUM_IN*FLIT_W-1:0] fin_req_i;
    logic [NUM_IN-1:0]        fin_resp_o;
    logic [FLIT_W-1:0]        fout_req_o;
    logic                     fout_resp_i;

    modport master (
        output fin_req_i,
        output fout_resp_i,
        input  fin_resp_o,
        input  fout_req_o
    );

    modport slave (
        input  fin_req_i,
        input  fout_resp_i,
        output fin_resp_o,
        output fout_req_o
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Router output stage: round-robin arbitration of NUM_IN input datapaths onto one output link,
// with a wormhole lock held from HEAD to TAIL so packets never interleave, and a single
// registered output stage using valid/ready.
// Ports:
//   clk          clock, rising edge
//   arst         asynchronous active-low reset
//   bus          flit request/response bundle (slave side)
//   lock_o       high while a wormhole lock is held
//   grant_idx_o  index of the current or last granted input
//   proto_err_o  one-cycle pulse, aligned with the offending flit on the output
module output_port_arbiter #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned FLIT_W = 37
) (
    input  logic                 clk,
    input  logic                 arst,
    output_port_arbiter_if.slave bus,
    output logic                 lock_o,
    output logic [2:0]           grant_idx_o,
    output logic                 proto_err_o
);

    localparam logic [1:0] FtHead     = 2'b00;
    localparam logic [1:0] FtBody     = 2'b01;
    localparam logic [1:0] FtTail     = 2'b10;
    localparam logic [1:0] FtHeadTail = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        rr_q, rr_d;
    // While locked, grant_q is also the locked input index.
    logic [2:0]        grant_q, grant_d;
    logic              err_q, err_d;
    logic [FLIT_W-1:0] fout_q, fout_d;

    logic [7:0]        in_valid;
    logic [FLIT_W-1:0] flit_arr [8];
    logic [3:0]        scan_idx;
    logic [2:0]        scan_sel;
    logic              scan_found;
    logic [2:0]        sel;
    logic              sel_valid;
    logic              grant_ok;
    logic              can_load;
    logic              xfer;
    logic [FLIT_W-1:0] sel_flit;
    logic [1:0]        sel_type;

    function automatic logic [2:0] next_idx(logic [2:0] idx);
        return (32'(idx) == NUM_IN - 1) ? 3'd0 : idx + 3'd1;
    endfunction

    // Unpack inputs into an 8-entry array so any 3-bit index is in range.
    always_comb begin
        in_valid = '0;
        for (int k = 0; k < 8; k++) begin
            flit_arr[k] = '0;
        end
        for (int k = 0; k < int'(NUM_IN); k++) begin
            flit_arr[k] = bus.fin_req_i[k*FLIT_W +: FLIT_W];
            in_valid[k] = flit_arr[k][0];
        end
    end

    // Round-robin scan starting at rr_q, wrapping modulo NUM_IN.
    always_comb begin
        scan_found = 1'b0;
        scan_sel   = rr_q;
        scan_idx   = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            scan_idx = {1'b0, rr_q} + 4'(i);
            if (scan_idx >= 4'(NUM_IN)) begin
                scan_idx = scan_idx - 4'(NUM_IN);
            end
            if (!scan_found && in_valid[scan_idx[2:0]]) begin
                scan_found = 1'b1;
                scan_sel   = scan_idx[2:0];
            end
        end
    end

    always_comb begin
        sel       = scan_sel;
        sel_valid = scan_found;
        grant_ok  = scan_found;
        if (state_q == StLocked) begin
            sel       = grant_q;
            sel_valid = in_valid[grant_q];
            grant_ok  = 1'b1;
        end
    end

    assign can_load = ~fout_q[0] | bus.fout_resp_i;
    assign xfer     = sel_valid & can_load;
    assign sel_flit = flit_arr[sel];
    assign sel_type = sel_flit[FLIT_W-1 -: 2];

    // Ready is forced low while reset is asserted so no input believes a flit was taken.
    always_comb begin
        bus.fin_resp_o = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            bus.fin_resp_o[k] = arst & can_load & grant_ok & (sel == 3'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        err_d   = 1'b0;
        if (xfer) begin
            unique case (state_q)
                StIdle: begin
                    grant_d = sel;
                    case (sel_type)
                        FtHead:     state_d = StLocked;
                        FtHeadTail: rr_d = next_idx(sel);
                        default: begin
                            // Stray BODY/TAIL: forward it but flag it.
                            rr_d  = next_idx(sel);
                            err_d = 1'b1;
                        end
                    endcase
                end
                StLocked: begin
                    case (sel_type)
                        FtTail: begin
                            state_d = StIdle;
                            rr_d    = next_idx(grant_q);
                        end
                        FtBody:  state_d = StLocked;
                        default: err_d = 1'b1;
                    endcase
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output register: load on transfer, otherwise drop valid once the old flit retires.
    always_comb begin
        fout_d = fout_q;
        if (can_load) begin
            if (xfer) begin
                fout_d = sel_flit;
            end else begin
                fout_d[0] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            fout_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            fout_q  <= fout_d;
        end
    end

    assign bus.fout_req_o = fout_q;
    assign lock_o         = (state_q == StLocked);
    assign grant_idx_o    = grant_q;
    assign proto_err_o    = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned W = 37;
    localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, HT = 2'b11;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       lock, err;
    logic [2:0] gidx;
    logic [W-1:0] fin [N];

    output_port_arbiter_if #(.NUM_IN(N), .FLIT_W(W)) bus ();

    output_port_arbiter #(.NUM_IN(N), .FLIT_W(W)) dut (
        .clk         (clk),
        .arst        (arst),
        .bus         (bus),
        .lock_o      (lock),
        .grant_idx_o (gidx),
        .proto_err_o (err)
    );

    always #5 clk = ~clk;
    assign bus.fin_req_i = {fin[3], fin[2], fin[1], fin[0]};

    int n_chk = 0;
    int n_err = 0;
    int unsigned tag_ctr = 1;

    // Reference model state and scoreboard of flits expected on the output.
    bit m_lock, m_valid, m_err;
    int m_rr, m_grant;
    logic [W-1:0] sb [$];

    typedef struct packed {
        logic [3:0] v;
        logic [7:0] t;
        logic       rdy;
        logic [3:0] resp;
        logic       lock;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int k, input logic [1:0] t, input int unsigned tag);
        return {t, 8'(k), 24'(tag), 2'(k), 1'b1};
    endfunction

    task automatic set_inputs(input logic [3:0] v, input logic [7:0] t);
        for (int k = 0; k < int'(N); k++) begin
            if (v[k]) fin[k] = mk(k, t[2*k +: 2], tag_ctr);
            else fin[k] = '0;
            tag_ctr++;
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_valid = 0; m_err = 0; m_rr = 0; m_grant = 0;
        sb.delete();
    endtask

    // One clock: check ready at the negedge, then check registered outputs #1 after the edge.
    task automatic cycle(output logic [3:0] resp_seen);
        bit can, has, ok, xfer;
        int s;
        logic [1:0] ft;
        logic [3:0] exp_resp;
        bit n_lock, n_valid, n_err;
        int n_rr, n_grant;
        @(negedge clk);
        resp_seen = bus.fin_resp_o;
        if (bus.fout_req_o[0] && bus.fout_resp_i) begin
            if (sb.size() == 0) chk("sb_retire_empty", 64'd1, 64'd0);
            else void'(sb.pop_front());
        end
        can = !m_valid || bus.fout_resp_i;
        s = 0; has = 0;
        if (m_lock) begin
            s = m_grant; has = fin[s][0]; ok = 1;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                int j;
                j = (m_rr + i) % N;
                if (!has && fin[j][0]) begin s = j; has = 1; end
            end
            ok = has;
        end
        exp_resp = (can && ok) ? 4'(1 << s) : 4'd0;
        chk("fin_resp", 64'(resp_seen), 64'(exp_resp));
        xfer = has && can;
        n_lock = m_lock; n_rr = m_rr; n_grant = m_grant; n_err = 0;
        n_valid = can ? xfer : m_valid;
        if (xfer) begin
            sb.push_back(fin[s]);
            ft = fin[s][36:35];
            if (!m_lock) begin
                n_grant = s;
                if (ft == HD) n_lock = 1;
                else n_rr = (s + 1) % N;
                if (ft == BD || ft == TL) n_err = 1;
            end else begin
                if (ft == TL) begin n_lock = 0; n_rr = (m_grant + 1) % N; end
                else if (ft != BD) n_err = 1;
            end
        end
        @(posedge clk);
        #1;
        m_lock = n_lock; m_rr = n_rr; m_grant = n_grant; m_err = n_err; m_valid = n_valid;
        chk("fout_valid", 64'(bus.fout_req_o[0]), 64'(m_valid));
        if (bus.fout_req_o[0]) begin
            if (sb.size() == 0) chk("sb_peek_empty", 64'd1, 64'd0);
            else chk("fout_data", 64'(bus.fout_req_o), 64'(sb[0]));
        end
        chk("lock_o", 64'(lock), 64'(m_lock));
        chk("grant_idx", 64'(gidx), 64'(m_grant));
        chk("proto_err", 64'(err), 64'(m_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [W-1:0] x, y;
        tbl[0]  = '{v: 4'b0100, t: 8'hFF, rdy: 1, resp: 4'b0100, lock: 0};
        tbl[1]  = '{v: 4'b0000, t: 8'hFF, rdy: 1, resp: 4'b0000, lock: 0};
        tbl[2]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b1000, lock: 0};
        tbl[3]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b0001, lock: 0};
        tbl[4]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b0010, lock: 0};
        tbl[5]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b0100, lock: 0};
        tbl[6]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b1000, lock: 0};
        tbl[7]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b0001, lock: 0};
        tbl[8]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b0010, lock: 0};
        tbl[9]  = '{v: 4'b1111, t: 8'hFF, rdy: 1, resp: 4'b0100, lock: 0};
        tbl[10] = '{v: 4'b0011, t: {HT, HT, HT, HD}, rdy: 1, resp: 4'b0001, lock: 1};
        tbl[11] = '{v: 4'b0010, t: {HT, HT, HT, HD}, rdy: 1, resp: 4'b0001, lock: 1};
        tbl[12] = '{v: 4'b0011, t: {HT, HT, HT, BD}, rdy: 1, resp: 4'b0001, lock: 1};
        tbl[13] = '{v: 4'b0011, t: {HT, HT, HT, TL}, rdy: 1, resp: 4'b0001, lock: 0};
        tbl[14] = '{v: 4'b0010, t: {HT, HT, HT, HT}, rdy: 1, resp: 4'b0010, lock: 0};

        // Reset held with an input active.
        model_reset();
        bus.fout_resp_i = 1'b1;
        set_inputs(4'b0100, 8'hFF);
        #12;
        chk("rst_fout", 64'(bus.fout_req_o), 64'd0);
        chk("rst_resp", 64'(bus.fin_resp_o), 64'd0);
        chk("rst_lock", 64'(lock), 64'd0);
        chk("rst_gidx", 64'(gidx), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1 arst = 1'b1;

        // Table: single HEAD_TAIL, round-robin with wrap, wormhole packet with a competitor.
        for (int i = 0; i < 15; i++) begin
            set_inputs(tbl[i].v, tbl[i].t);
            bus.fout_resp_i = tbl[i].rdy;
            cycle(r);
            chk($sformatf("tbl%0d_resp", i), 64'(r), 64'(tbl[i].resp));
            chk($sformatf("tbl%0d_lock", i), 64'(lock), 64'(tbl[i].lock));
        end

        // Downstream stall with X buffered and in3 waiting.
        set_inputs(4'b0100, 8'hFF);
        x = fin[2];
        cycle(r);
        chk("stall_load", 64'(bus.fout_req_o), 64'(x));
        set_inputs(4'b1000, 8'hFF);
        y = fin[3];
        bus.fout_resp_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(r);
            chk("stall_resp", 64'(r), 64'd0);
            chk("stall_hold", 64'(bus.fout_req_o), 64'(x));
        end
        bus.fout_resp_i = 1'b1;
        cycle(r);
        chk("unstall_resp", 64'(r), 64'b1000);
        chk("unstall_next", 64'(bus.fout_req_o), 64'(y));
        set_inputs(4'b0000, 8'hFF);
        cycle(r);

        // Stray BODY in IDLE: forwarded, one-cycle error pulse.
        set_inputs(4'b0010, {HT, HT, BD, HT});
        cycle(r);
        chk("body_resp", 64'(r), 64'b0010);
        chk("body_err", 64'(err), 64'd1);
        set_inputs(4'b0000, 8'hFF);
        cycle(r);
        chk("body_err_clr", 64'(err), 64'd0);

        // Lock on in0, repeated HEAD while locked, then reset mid-packet.
        set_inputs(4'b0001, {HT, HT, HT, HD});
        cycle(r);
        chk("lk_lock", 64'(lock), 64'd1);
        set_inputs(4'b0001, {HT, HT, HT, HD});
        cycle(r);
        chk("lk_err", 64'(err), 64'd1);
        chk("lk_keep", 64'(lock), 64'd1);
        set_inputs(4'b0001, {HT, HT, HT, BD});
        cycle(r);
        #2 arst = 1'b0;
        #1;
        chk("mid_rst_lock", 64'(lock), 64'd0);
        chk("mid_rst_fout", 64'(bus.fout_req_o), 64'd0);
        chk("mid_rst_gidx", 64'(gidx), 64'd0);
        chk("mid_rst_resp", 64'(bus.fin_resp_o), 64'd0);
        model_reset();
        @(posedge clk);
        #1 arst = 1'b1;
        set_inputs(4'b1000, 8'hFF);
        cycle(r);
        chk("post_rst_resp", 64'(r), 64'b1000);
        set_inputs(4'b0000, 8'hFF);
        cycle(r);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
